// File: rtl/modem_ctrl_pkg.sv
// Shared definitions for the FTDI modem-control monitor: default timing
// constants derived from the 12 MHz board clock and the host-reset FSM states.
package modem_ctrl_pkg;

  // Board clock rate the default timing constants are derived from.
  localparam int CLK_HZ = 12_000_000;

  // 1 ms of stable level before a debounced line is allowed to flip.
  localparam int DEBOUNCE_MAX_DEF = CLK_HZ / 1000;

  // 10 ms of debounced DTR assertion qualifies as a host-reset request.
  localparam int PULSE_MIN_DEF = CLK_HZ / 100;

  // Host-reset detector states. The encoding is visible on the debug port.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    QUALIFIED = 2'd2
  } host_rst_state_t;

endpackage

// File: rtl/modem_line_debounce.sv
// One host modem-control line: two-flop synchronizer, mismatch-run debounce
// counter, clean active-high level and registered rise/fall pulses.
// The pin is active-low; the synchronizer resets to 1 so a line reads
// deasserted straight out of reset.
module modem_line_debounce
  import modem_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEF,
  parameter int DEBOUNCE_W   = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_MAX - 1);

  logic                  sync_1;
  logic                  sync_2;
  logic                  synced;
  logic [DEBOUNCE_W-1:0] cnt;

  // Asserted-high view of the synchronized pin.
  assign synced = ~sync_2;

  // Two-stage synchronizer for the asynchronous host pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= pin_n;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive mismatches; flip the level and pulse once the run is long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        rise  <= synced;
        fall  <= ~synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DEBOUNCE_W'(1);
      end
    end
  end

endmodule

// File: rtl/modem_ctrl_monitor.sv
// Receive-side monitor for the icestick FTDI modem-control lines.
// Debounces DTR_N/RTS_N, counts debounced edges, and flags a long DTR
// assertion followed by release as a one-cycle host-reset request.
// Optional feature macro: MODEM_LOOPBACK_EN -- when defined, DSR_N/CTS_N
// echo the debounced DTR/RTS one cycle after the level flips; otherwise
// they are tied deasserted.
module modem_ctrl_monitor
  import modem_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_DEF,
  parameter int DEBOUNCE_W   = 14,
  parameter int PULSE_MIN    = PULSE_MIN_DEF,
  parameter int PULSE_W      = 17
) (
  input  logic            CLKIN,
  input  logic            RESET,
  input  logic            DTR_N,
  input  logic            RTS_N,
  output logic            DTR,
  output logic            RTS,
  output logic            DTR_RISE,
  output logic            DTR_FALL,
  output logic            RTS_RISE,
  output logic            RTS_FALL,
  output logic            HOST_RST,
  output logic [7:0]      EVT_CNT,
  output logic            DSR_N,
  output logic            CTS_N,
  output host_rst_state_t fsm_state
);

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_MIN - 1);

  host_rst_state_t    state;
  host_rst_state_t    state_next;
  logic [PULSE_W-1:0] pcnt;
  logic [PULSE_W-1:0] pcnt_next;
  logic               host_rst_next;

  modem_line_debounce #(
    .DEBOUNCE_MAX (DEBOUNCE_MAX),
    .DEBOUNCE_W   (DEBOUNCE_W)
  ) u_dtr (
    .clk   (CLKIN),
    .rst   (RESET),
    .pin_n (DTR_N),
    .level (DTR),
    .rise  (DTR_RISE),
    .fall  (DTR_FALL)
  );

  modem_line_debounce #(
    .DEBOUNCE_MAX (DEBOUNCE_MAX),
    .DEBOUNCE_W   (DEBOUNCE_W)
  ) u_rts (
    .clk   (CLKIN),
    .rst   (RESET),
    .pin_n (RTS_N),
    .level (RTS),
    .rise  (RTS_RISE),
    .fall  (RTS_FALL)
  );

  // Host-reset FSM state and pulse-length counter registers.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state <= IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_next;
      pcnt  <= pcnt_next;
    end
  end

  // Next-state logic. HOST_RST is decoded from registered state and the
  // registered DTR level, so it lands in the same cycle as DTR_FALL.
  always_comb begin
    state_next    = state;
    pcnt_next     = pcnt;
    host_rst_next = 1'b0;
    case (state)
      IDLE: begin
        if (DTR) begin
          pcnt_next  = '0;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (!DTR) begin
          state_next = IDLE;
        end else begin
          pcnt_next = pcnt + PULSE_W'(1);
          if (pcnt_next == PULSE_LAST) begin
            state_next = QUALIFIED;
          end
        end
      end
      QUALIFIED: begin
        // Counter stays saturated until DTR releases.
        if (!DTR) begin
          host_rst_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign HOST_RST  = host_rst_next;
  assign fsm_state = state;

  // Accumulate debounced edges from both lines, wrapping modulo 256.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      EVT_CNT <= 8'd0;
    end else begin
      EVT_CNT <= EVT_CNT + {7'd0, DTR_RISE} + {7'd0, DTR_FALL}
                         + {7'd0, RTS_RISE} + {7'd0, RTS_FALL};
    end
  end

`ifdef MODEM_LOOPBACK_EN
  // Echo the debounced host lines back as modem status, one cycle behind.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      DSR_N <= 1'b1;
      CTS_N <= 1'b1;
    end else begin
      DSR_N <= ~DTR;
      CTS_N <= ~RTS;
    end
  end
`else
  assign DSR_N = 1'b1;
  assign CTS_N = 1'b1;
`endif

endmodule
